// File: rtl/uart_pkg.sv
// UART engine shared types: transmitter/receiver state encodings.
// Parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-rate tick generator: tx_tick every TX_DIV cycles, rx_tick at 16x.
// Both counters can be restarted to align ticks with a frame edge.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic clk,
    input  logic reset,
    input  logic tx_restart,
    input  logic rx_restart,
    output logic tx_tick,
    output logic rx_tick
);

    localparam int TX_DIV = CLK_HZ / BAUD;
    localparam int RX_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TX_W   = $clog2(TX_DIV + 1);
    localparam int RX_W   = $clog2(RX_DIV + 1);

    logic [TX_W-1:0] tx_cnt;
    logic [RX_W-1:0] rx_cnt;

    assign tx_tick = tx_cnt == TX_W'(TX_DIV - 1);
    assign rx_tick = rx_cnt == RX_W'(RX_DIV - 1);

    always_ff @(posedge clk) begin
        if (reset || tx_restart)
            tx_cnt <= '0;
        else if (tx_tick)
            tx_cnt <= '0;
        else
            tx_cnt <= tx_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || rx_restart)
            rx_cnt <= '0;
        else if (rx_tick)
            rx_cnt <= '0;
        else
            rx_cnt <= rx_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_engine.sv
// Full-duplex UART with 16x oversampled receiver and loopback mux.
// Define UART_PARITY_EN to add a parity bit, PARITY_ODD and parity_err.
module uart_engine
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
`ifdef UART_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              transmit,
    input  logic [DATA_W-1:0] TxData,
    output logic              TxD,
    output logic              busy,
    input  logic              RxD,
    input  logic              loopback,
    output logic [DATA_W-1:0] RxData,
    output logic              valid_rx,
    output logic              frame_err
`ifdef UART_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    tx_state_t         tx_state;
    logic [DATA_W-1:0] tx_sh;
    logic [3:0]        tx_bits;
    logic              tx_stops;
    logic              tx_tick;
    logic              tx_restart;

    rx_state_t         rx_state;
    logic [DATA_W-1:0] rx_sh;
    logic [3:0]        rx_bits;
    logic [3:0]        rx_ticks;
    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    logic              rx_tick;
    logic              rx_restart;
`ifdef UART_PARITY_EN
    logic              tx_par;
    logic              par_bad;
`endif

    assign tx_restart = (tx_state == TX_IDLE) && transmit;
    assign rx_restart = (rx_state == RX_IDLE) && rx_prev && !rx_sync;

    uart_baud_gen #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .tx_restart(tx_restart),
        .rx_restart(rx_restart),
        .tx_tick   (tx_tick),
        .rx_tick   (rx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            TxD      <= 1'b1;
            busy     <= 1'b0;
            tx_sh    <= '0;
            tx_bits  <= '0;
            tx_stops <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            unique case (tx_state)
                TX_IDLE: if (transmit) begin
                    tx_sh    <= TxData;
                    tx_bits  <= '0;
                    tx_stops <= 1'b0;
                    TxD      <= 1'b0;
                    busy     <= 1'b1;
                    tx_state <= TX_START;
`ifdef UART_PARITY_EN
                    tx_par   <= (^TxData) ^ PARITY_ODD;
`endif
                end
                TX_START: if (tx_tick) begin
                    TxD      <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_state <= TX_DATA;
                end
                TX_DATA: if (tx_tick) begin
                    if (tx_bits == 4'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                        TxD      <= tx_par;
                        tx_state <= TX_PARITY;
`else
                        TxD      <= 1'b1;
                        tx_state <= TX_STOP;
`endif
                    end else begin
                        tx_bits <= tx_bits + 4'd1;
                        TxD     <= tx_sh[0];
                        tx_sh   <= tx_sh >> 1;
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: if (tx_tick) begin
                    TxD      <= 1'b1;
                    tx_state <= TX_STOP;
                end
`endif
                TX_STOP: if (tx_tick) begin
                    if (tx_stops == 1'(STOP_BITS - 1)) begin
                        busy     <= 1'b0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_stops <= 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Line choice happens before the synchroniser so loopback is also retimed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= loopback ? TxD : RxD;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_sh      <= '0;
            rx_bits    <= '0;
            rx_ticks   <= '0;
            RxData     <= '0;
            valid_rx   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            valid_rx   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            unique case (rx_state)
                RX_IDLE: if (rx_restart) begin
                    rx_ticks <= '0;
                    rx_state <= RX_START;
                end
                RX_START: if (rx_tick) begin
                    if (rx_ticks == 4'd7) begin
                        rx_ticks <= '0;
                        rx_bits  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_ticks <= rx_ticks + 4'd1;
                    end
                end
                RX_DATA: if (rx_tick) begin
                    rx_ticks <= rx_ticks + 4'd1;
                    if (rx_ticks == 4'd15) begin
                        rx_sh <= {rx_sync, rx_sh[DATA_W-1:1]};
                        if (rx_bits == 4'(DATA_W - 1))
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        else
                            rx_bits <= rx_bits + 4'd1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: if (rx_tick) begin
                    rx_ticks <= rx_ticks + 4'd1;
                    if (rx_ticks == 4'd15) begin
                        par_bad  <= rx_sync ^ (^rx_sh) ^ PARITY_ODD;
                        rx_state <= RX_STOP;
                    end
                end
`endif
                RX_STOP: if (rx_tick) begin
                    rx_ticks <= rx_ticks + 4'd1;
                    if (rx_ticks == 4'd15) begin
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_WAIT_HIGH;
`ifdef UART_PARITY_EN
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
                            rx_state   <= RX_IDLE;
`endif
                        end else begin
                            RxData   <= rx_sh;
                            valid_rx <= 1'b1;
                            rx_state <= RX_IDLE;
                        end
                    end
                end
                RX_WAIT_HIGH: if (rx_sync) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_engine.sv
// Scoreboard bench for uart_engine: expected receive events are queued
// by stimulus and popped by a monitor on valid_rx/frame_err/parity_err.
module tb_uart_engine;

    localparam int TX_DIV = 434;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       transmit;
    logic [7:0] TxData;
    logic       TxD;
    logic       busy;
    logic       RxD;
    logic       loopback;
    logic [7:0] RxData;
    logic       valid_rx;
    logic       frame_err;
    logic       parity_err;

    int n_cmp = 0;
    int n_bad = 0;
    int ev_cnt = 0;
    logic [9:0] exp_q[$];
    logic [9:0] obs;
    logic [7:0] last_rx;

    always #5 clk = ~clk;

    uart_engine dut (
        .clk      (clk),
        .reset    (reset),
        .transmit (transmit),
        .TxData   (TxData),
        .TxD      (TxD),
        .busy     (busy),
        .RxD      (RxD),
        .loopback (loopback),
        .RxData   (RxData),
        .valid_rx (valid_rx),
`ifdef UART_PARITY_EN
        .frame_err(frame_err),
        .parity_err(parity_err)
`else
        .frame_err(frame_err)
`endif
    );

`ifndef UART_PARITY_EN
    assign parity_err = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // kind: 0 = good word, 1 = framing error, 2 = parity error
    always @(negedge clk) begin
        if (valid_rx || frame_err || parity_err) begin
            obs = {frame_err ? 2'd1 : (parity_err ? 2'd2 : 2'd0), RxData};
            ev_cnt++;
            if (exp_q.size() == 0)
                check("rx_event_queued", 32'(exp_q.size()), 32'd1);
            else
                check("rx_event", 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_busy(input logic v);
        int n;
        n = 0;
        while (busy !== v && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== v)
            check("busy_wait", 32'(busy), 32'(v));
    endtask

    task automatic drive_bit(input logic b);
        RxD = b;
        repeat (TX_DIV) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
    endtask

    task automatic expect_word(input logic [7:0] d);
        exp_q.push_back({2'd0, d});
        last_rx = d;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] msg[6];
        int n;
        int ev0;
        msg = '{8'h53, 8'h41, 8'h55, 8'h52, 8'h41, 8'h56};
        reset = 1'b1;
        transmit = 1'b0;
        TxData = 8'h00;
        RxD = 1'b1;
        loopback = 1'b0;
        last_rx = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(TxD), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rxdata", 32'(RxData), 32'h00);
        check("rst_valid", 32'(valid_rx), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // single loopback byte
        loopback = 1'b1;
        expect_word(8'h53);
        TxData = 8'h53;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        check("tx_busy_rise", 32'(busy), 32'd1);
        check("tx_start_bit", 32'(TxD), 32'd0);
        n = 0;
        while (busy && n < 6000) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", 32'(n), 32'(FRAME_BITS * TX_DIV));
        repeat (50) @(negedge clk);
        check("rx_0x53", 32'(RxData), 32'h53);

        // back-to-back frames with transmit held high
        for (int i = 0; i < 6; i++) expect_word(msg[i]);
        TxData = msg[0];
        transmit = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check("zero_gap", 32'(busy), 32'd1);
            end else begin
                wait_busy(1'b1);
            end
            if (i == 5) transmit = 1'b0;
            wait_busy(1'b0);
            if (i < 5) TxData = msg[i + 1];
        end
        repeat (200) @(negedge clk);
        check("rx_last_V", 32'(RxData), 32'h56);

        // transmit pulse and TxData change while busy are ignored
        expect_word(8'h41);
        TxData = 8'h41;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        TxData = 8'hFF;
        n = 0;
        while (busy && n < 6000) begin
            n++;
            transmit = (n == 1000);
            @(negedge clk);
        end
        transmit = 1'b0;
        check("busy_len_ignored", 32'(n), 32'(FRAME_BITS * TX_DIV));
        repeat (20) @(negedge clk);
        check("no_restart", 32'(busy), 32'd0);
        repeat (100) @(negedge clk);

        // external frame with low stop bit, then a break, then a good frame
        loopback = 1'b0;
        exp_q.push_back({2'd1, last_rx});
        send_rx(8'hA5, 1'b0);
        repeat (2000) @(negedge clk);
        check("ferr_hold", 32'(RxData), 32'h41);
        RxD = 1'b1;
        repeat (500) @(negedge clk);
        expect_word(8'h3C);
        send_rx(8'h3C, 1'b1);
        repeat (300) @(negedge clk);
        check("rx_0x3C", 32'(RxData), 32'h3C);

        // short low glitch is a false start
        ev0 = ev_cnt;
        RxD = 1'b0;
        repeat (81) @(negedge clk);
        RxD = 1'b1;
        repeat (1000) @(negedge clk);
        check("glitch_silent", 32'(ev_cnt), 32'(ev0));

        // reset in the middle of data bit 4
        loopback = 1'b1;
        TxData = 8'h5A;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        repeat (5 * TX_DIV + 200) @(negedge clk);
        ev0 = ev_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_txd", 32'(TxD), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rxdata", 32'(RxData), 32'h00);
        reset = 1'b0;
        last_rx = 8'h00;
        repeat (5000) @(negedge clk);
        check("mid_rst_silent", 32'(ev_cnt), 32'(ev0));
        check("idle_busy", 32'(busy), 32'd0);

`ifdef UART_PARITY_EN
        // 0x07 has three ones: even parity bit should be 1, send 0
        loopback = 1'b0;
        exp_q.push_back({2'd2, last_rx});
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i < 3);
        drive_bit(1'b0);
        drive_bit(1'b1);
        repeat (300) @(negedge clk);
        check("perr_hold", 32'(RxData), 32'h00);
        expect_word(8'h07);
        send_rx(8'h07, 1'b1);
        repeat (300) @(negedge clk);
        check("rx_0x07", 32'(RxData), 32'h07);
`endif

        repeat (100) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
